mul_div_unit: RTL and testbench

- Parametrised multi-cycle signed multiply/divide engine for the datapath.
- Replaces single-cycle MUL/DIV evaluation in the combinational ALU.
- Multiply uses radix-4 Booth (bit-pair recoding); divide uses non-restoring division.
- Results go to Chigh/Clow, which feed the HI/LO registers. Control handshake is start/busy/done.

---
 rtl/mul_div_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) engine feeding HI/LO.
// Latency from accepting edge: MUL WIDTH/2+1, DIV WIDTH+2, DIV by zero 1 (MUL WIDTH/2+2 unsigned).
// No backpressure: start is taken only in IDLE and is dropped otherwise. MULDIV_UNSIGNED_EN adds is_unsigned.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             MUL,
    input  logic             DIV,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Chigh,
    output logic [WIDTH-1:0] Clow
);
    localparam int W2 = 2 * WIDTH;
    localparam int RW = WIDTH + 2;          // partial remainder / divisor, signed, room for 2*|B|
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [2:0] {IDLE, MUL_ITER, DIV_ITER, DIV_FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d;          // product, or {remainder, quotient} once fixed up
    logic [W2-1:0]   mcand_q, mcand_d;      // extended multiplicand, shifted by 2 per digit
    logic [RW-1:0]   mplr_q, mplr_d;        // multiplier, consumed 2 bits per digit
    logic            prev_q, prev_d;        // bit below the current Booth pair
    logic [RW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [RW-1:0]   dvs_q, dvs_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            dz_q, dz_d;            // current op is a divide by zero
    logic            uns_q, uns_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic [WIDTH-1:0] chigh_q, chigh_d;
    logic [WIDTH-1:0] clow_q, clow_d;

    logic             uns_req;
`ifdef MULDIV_UNSIGNED_EN
    assign uns_req = is_unsigned;
`else
    assign uns_req = 1'b0;
`endif

    // Operand preparation at the accepting edge
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [W2-1:0]    a_ext;
    logic [RW-1:0]    b_ext;
    assign a_neg = A[WIDTH-1] & ~uns_req;
    assign b_neg = B[WIDTH-1] & ~uns_req;
    assign a_mag = a_neg ? -A : A;          // most-negative maps onto itself = 2^(WIDTH-1) unsigned
    assign b_mag = b_neg ? -B : B;
    assign a_ext = uns_req ? {{WIDTH{1'b0}}, A} : {{WIDTH{A[WIDTH-1]}}, A};
    assign b_ext = uns_req ? {2'b00, B} : {B[WIDTH-1], B[WIDTH-1], B};

    // Booth digit selection and divide step datapath
    logic [W2-1:0]    addend;
    logic [RW-1:0]    r_sh, r_new;
    logic [WIDTH-1:0] r_fix, r_out, q_out;
    always_comb begin
        addend = '0;
        case ({mplr_q[1:0], prev_q})
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = {mcand_q[W2-2:0], 1'b0};
            3'b100:         addend = -{mcand_q[W2-2:0], 1'b0};
            3'b101, 3'b110: addend = -mcand_q;
            default:        addend = '0;
        endcase
        r_sh  = {rem_q[RW-2:0], quo_q[WIDTH-1]};
        r_new = rem_q[RW-1] ? (r_sh + dvs_q) : (r_sh - dvs_q);
        r_fix = rem_q[WIDTH-1:0] + (rem_q[RW-1] ? dvs_q[WIDTH-1:0] : {WIDTH{1'b0}});
        r_out = negr_q ? -r_fix : r_fix;
        q_out = negq_q ? -quo_q : quo_q;
    end

    // Next-state and control sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        prev_d  = prev_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        uns_d   = uns_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        chigh_d = chigh_q;
        clow_d  = clow_q;
        case (state_q)
            IDLE: begin
                if (start && (MUL ^ DIV)) begin
                    dbz_d = 1'b0;
                    dz_d  = 1'b0;
                    uns_d = uns_req;
                    if (MUL) begin
                        acc_d   = '0;
                        mcand_d = a_ext;
                        mplr_d  = b_ext;
                        prev_d  = 1'b0;
                        // unsigned needs one extra digit to cover the zero-extended top bit
                        cnt_d   = uns_req ? CW'(WIDTH / 2) : CW'(WIDTH / 2 - 1);
                        state_d = MUL_ITER;
                    end else if (B == '0) begin
                        acc_d   = {A, {WIDTH{1'b1}}};
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvs_d   = {2'b00, b_mag};
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = DIV_ITER;
                    end
                end
            end
            MUL_ITER: begin
                acc_d   = acc_q + addend;
                mcand_d = {mcand_q[W2-3:0], 2'b00};
                mplr_d  = {2'b00, mplr_q[RW-1:2]};
                prev_d  = mplr_q[1];
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = DONE;
            end
            DIV_ITER: begin
                rem_d = r_new;
                quo_d = {quo_q[WIDTH-2:0], ~r_new[RW-1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                acc_d   = {r_out, q_out};
                state_d = DONE;
            end
            DONE: begin
                chigh_d = acc_q[W2-1:WIDTH];
                clow_d  = acc_q[WIDTH-1:0];
                done_d  = 1'b1;
                dbz_d   = dz_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            prev_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            uns_q   <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            chigh_q <= '0;
            clow_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prev_q  <= prev_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            uns_q   <= uns_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            chigh_q <= chigh_d;
            clow_q  <= clow_d;
        end
    end

    assign busy        = (state_q == MUL_ITER) || (state_q == DIV_ITER) || (state_q == DIV_FIX);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign Chigh       = chigh_q;
    assign Clow        = clow_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32 with hand-computed results.
// Measures done latency and busy duration from the accepting edge.
// Exercises ignored starts, mid-operation clear and invalid opcode selection.
module tb_mul_div_unit;
    logic        clock, clear, start, MUL, DIV;
    logic [31:0] A, B;
    logic        busy, done, div_by_zero;
    logic [31:0] Chigh, Clow;

    int n_vec = 0;
    int n_err = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .MUL(MUL), .DIV(DIV),
        .A(A), .B(B), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .Chigh(Chigh), .Clow(Clow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency and busy cycles, check results.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int lat;
        int nb;
        @(negedge clock);
        MUL = m; DIV = d; A = a; B = b; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; MUL = 1'b0; DIV = 1'b0; A = ~a; B = ~b;
        lat = 0;
        nb  = 0;
        if (busy) nb++;
        while (!done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            if (busy) nb++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".busy"}, 64'(nb), 64'(exp_busy));
        check({tag, ".hi"}, {32'h0, Chigh}, {32'h0, exp_hi});
        check({tag, ".lo"}, {32'h0, Clow}, {32'h0, exp_lo});
        check({tag, ".dz"}, {63'h0, div_by_zero}, {63'h0, exp_dz});
        @(posedge clock);
        #1;
        check({tag, ".pulse"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        int ndone;
        clear = 1'b1; start = 1'b0; MUL = 1'b0; DIV = 1'b0; A = '0; B = '0;
        #22;
        check("rst.busy", {63'h0, busy}, 64'h0);
        check("rst.done", {63'h0, done}, 64'h0);
        check("rst.dz", {63'h0, div_by_zero}, 64'h0);
        check("rst.res", {Chigh, Clow}, 64'h0);
        @(negedge clock);
        clear = 1'b0;

        // multiplies
        run_op("mul7x-3", 1, 0, 32'd7, 32'hFFFFFFFD, 17, 16, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        repeat (3) @(posedge clock);
        #1;
        check("hold.lo", {32'h0, Clow}, 64'h0000_0000_FFFF_FFEB);
        run_op("mulmin2", 1, 0, 32'h80000000, 32'h80000000, 17, 16, 32'h40000000, 32'h00000000, 0);
        run_op("mulmax2", 1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 17, 16, 32'h3FFFFFFF, 32'h00000001, 0);
        run_op("mul-5x6", 1, 0, 32'hFFFFFFFB, 32'd6, 17, 16, 32'hFFFFFFFF, 32'hFFFFFFE2, 0);

        // divides
        run_op("div-7/2", 0, 1, 32'hFFFFFFF9, 32'd2, 34, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div5/0", 0, 1, 32'd5, 32'd0, 1, 0, 32'h00000005, 32'hFFFFFFFF, 1);
        repeat (4) @(posedge clock);
        #1;
        check("dz.held", {63'h0, div_by_zero}, 64'h1);
        run_op("div100/7", 0, 1, 32'd100, 32'd7, 34, 33, 32'd2, 32'd14, 0);
        run_op("divmin/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 34, 33, 32'h00000000, 32'h80000000, 0);
        run_op("div7/-2", 0, 1, 32'd7, 32'hFFFFFFFE, 34, 33, 32'd1, 32'hFFFFFFFD, 0);
        run_op("div-7/-2", 0, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 34, 33, 32'hFFFFFFFF, 32'd3, 0);

        // start while busy is ignored, not queued
        @(negedge clock);
        MUL = 1'b1; A = 32'd3; B = 32'd4; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; MUL = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        start = 1'b1; DIV = 1'b1; A = 32'd50; B = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0; DIV = 1'b0;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("ign.lat", 64'(i + 4), 64'd17);
                    check("ign.lo", {32'h0, Clow}, 64'd12);
                end
            end
        end
        check("ign.ndone", 64'(ndone), 64'd1);

        // clear mid-operation aborts without done
        @(negedge clock);
        MUL = 1'b1; A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; MUL = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        clear = 1'b1;
        #1;
        check("clr.busy", {63'h0, busy}, 64'h0);
        check("clr.res", {Chigh, Clow}, 64'h0);
        @(negedge clock);
        clear = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        check("clr.ndone", 64'(ndone), 64'd0);

        // both opcode selects high: stay idle
        @(negedge clock);
        MUL = 1'b1; DIV = 1'b1; A = 32'd2; B = 32'd2; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; MUL = 1'b0; DIV = 1'b0;
        check("both.busy", {63'h0, busy}, 64'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        check("both.ndone", 64'(ndone), 64'd0);

        // still operational afterwards
        run_op("mul-1x-1", 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 17, 16, 32'h00000000, 32'h00000001, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
